// File: rtl/gpia_bit.sv
// gpia_bit: output latch cell of the General-Purpose Interface Adapter.
//
// Holds a WIDTH-bit output value. On every rising clk_i edge where stb_i is
// high, the stored value is updated bitwise according to mode_i:
//   0 = write  (q <= d)
//   1 = set    (q <= q | d)
//   2 = clear  (q <= q & ~d)
//   3 = toggle (q <= q ^ d)
// With stb_i low, the value holds.
//
// Ports:
//   clk_i   in   1      system clock, rising edge active
//   res_i   in   1      asynchronous active-low reset, loads RESET_VALUE
//   mode_i  in   2      operation select
//   d_i     in   WIDTH  data / bit mask operand
//   stb_i   in   1      strobe, applies the selected operation
//   q_o     out  WIDTH  registered output value
module gpia_bit #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             stb_i,
  output logic [WIDTH-1:0] q_o
);

  typedef enum logic [1:0] {
    MODE_WRITE  = 2'd0,
    MODE_SET    = 2'd1,
    MODE_CLEAR  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;

  // Next-value selection: apply the requested bitwise operation on a strobe.
  always_comb begin
    q_next_s = q_r;
    if (stb_i) begin
      case (mode_e'(mode_i))
        MODE_WRITE:  q_next_s = d_i;
        MODE_SET:    q_next_s = q_r | d_i;
        MODE_CLEAR:  q_next_s = q_r & ~d_i;
        MODE_TOGGLE: q_next_s = q_r ^ d_i;
        default:     q_next_s = q_r;
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // Storage register; reset is asynchronous and overrides any strobe.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      q_r <= RESET_VALUE;
    end else begin
      q_r <= q_next_s;
    end
  end

  // Output comes straight from the register, no path from the inputs.
  assign q_o = q_r;

endmodule

// File: tb/tb_gpia_bit.sv
// Self-checking bench for gpia_bit: a 1-bit cell (default parameters) and an
// 8-bit cell with a non-zero reset value, checked against a per-bit
// behavioural model under directed and random stimulus.
module tb_gpia_bit;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk;
  logic       res;
  logic [1:0] mode;
  logic       stb;
  logic       d_a;
  logic [7:0] d_b;
  logic       q_a;
  logic [7:0] q_b;

  logic [7:0] ref_a;
  logic [7:0] ref_b;

  int total;
  int bad;

  gpia_bit dut_a (
    .clk_i  (clk),
    .res_i  (res),
    .mode_i (mode),
    .d_i    (d_a),
    .stb_i  (stb),
    .q_o    (q_a)
  );

  gpia_bit #(.WIDTH(8), .RESET_VALUE(RV8)) dut_b (
    .clk_i  (clk),
    .res_i  (res),
    .mode_i (mode),
    .d_i    (d_b),
    .stb_i  (stb),
    .q_o    (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Per-bit reference: a masked bit is forced to 1 (write/set), 0 (clear)
  // or inverted (toggle); an unmasked bit is unchanged except under write.
  function automatic logic [7:0] model_op(input logic [7:0] q, input logic [1:0] m,
                                          input logic [7:0] d, input int w);
    logic [7:0] r;
    r = q;
    for (int i = 0; i < w; i++) begin
      if (d[i]) begin
        if (m == 2'd2)      r[i] = 1'b0;
        else if (m == 2'd3) r[i] = ~q[i];
        else                r[i] = 1'b1;
      end else if (m == 2'd0) begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic step(input logic s, input logic [1:0] m, input logic da, input logic [7:0] db,
                      input string tag);
    @(negedge clk);
    stb  = s;
    mode = m;
    d_a  = da;
    d_b  = db;
    @(posedge clk);
    #1;
    if (s) begin
      ref_a = model_op(ref_a, m, {7'd0, da}, 1);
      ref_b = model_op(ref_b, m, db, 8);
    end
    check({tag, "_a"}, {7'd0, q_a}, ref_a);
    check({tag, "_b"}, q_b, ref_b);
  endtask

  task automatic release_reset();
    @(negedge clk);
    res = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    res   = 1'b1;
    stb   = 1'b0;
    mode  = 2'd0;
    d_a   = 1'b0;
    d_b   = 8'h00;
    ref_a = 8'h00;
    ref_b = RV8;

    // Asynchronous reset before any clock edge
    #1 res = 1'b0;
    #1;
    check("rst_a", {7'd0, q_a}, 8'h00);
    check("rst_b", q_b, RV8);
    repeat (2) @(posedge clk);
    release_reset();

    // No strobe after release, then d=0 in every mode from q=0
    step(1'b0, 2'd0, 1'b0, 8'h00, "idle");
    for (int m = 0; m < 4; m++) step(1'b1, 2'(m), 1'b0, 8'h00, "d0_q0");

    // From q=0 with d=1 in every mode
    for (int m = 0; m < 4; m++) begin
      step(1'b1, 2'd2, 1'b1, 8'hFF, "clr_prep");
      step(1'b1, 2'(m), 1'b1, 8'h3C, "d1_q0");
    end

    // From q=1 with d=0, then with d=1
    for (int m = 0; m < 4; m++) begin
      step(1'b1, 2'd0, 1'b1, 8'hFF, "set_prep");
      step(1'b1, 2'(m), 1'b0, 8'h00, "d0_q1");
    end
    for (int m = 0; m < 4; m++) begin
      step(1'b1, 2'd0, 1'b1, 8'hFF, "set_prep");
      step(1'b1, 2'(m), 1'b1, 8'h5A, "d1_q1");
    end

    // Back-to-back toggles restore the value
    step(1'b1, 2'd3, 1'b1, 8'hC3, "tog1");
    step(1'b1, 2'd3, 1'b1, 8'hC3, "tog2");

    // Hold: q=1, clear mask presented without strobe
    step(1'b1, 2'd0, 1'b1, 8'hFF, "set_prep");
    for (int k = 0; k < 4; k++) step(1'b0, 2'd2, 1'b1, 8'hFF, "hold");

    // Random stimulus
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
           8'($urandom), "rnd");

    // Reset asserted between edges, strobe during reset ignored
    step(1'b1, 2'd0, 1'b1, 8'h0F, "pre_mid");
    @(negedge clk);
    #1 res = 1'b0;
    #1;
    ref_a = 8'h00;
    ref_b = RV8;
    check("mid_rst_a", {7'd0, q_a}, ref_a);
    check("mid_rst_b", q_b, ref_b);
    stb  = 1'b1;
    mode = 2'd0;
    d_a  = 1'b1;
    d_b  = 8'hFF;
    @(posedge clk);
    #1;
    check("rst_stb_a", {7'd0, q_a}, ref_a);
    check("rst_stb_b", q_b, ref_b);

    // Release with a strobe present on the first edge: it is applied
    @(negedge clk);
    res  = 1'b1;
    stb  = 1'b1;
    mode = 2'd3;
    d_a  = 1'b1;
    d_b  = 8'h81;
    @(posedge clk);
    #1;
    ref_a = model_op(ref_a, 2'd3, 8'h01, 1);
    ref_b = model_op(ref_b, 2'd3, 8'h81, 8);
    check("rel_stb_a", {7'd0, q_a}, ref_a);
    check("rel_stb_b", q_b, ref_b);

    for (int k = 0; k < 50; k++)
      step(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), "rnd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
